dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: requester 0 is the core data port, requester 1 is a loader/DMA that preloads benchmark data.
- Sits between the requesters and dmem. The grant is combinational within the request cycle.
- Arbitration is round-robin, with an optional bounded burst lock.
- Read data is returned to the requester that issued the read, tagged by a grant-id pipeline that matches dmem read latency.

Parameters:
- RD_LATENCY, 1, cycles from an issued read to valid m_rdata; legal values 1..4.
- MAX_BURST, 8, maximum consecutive grants to one locked requester while the other is waiting; legal values 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- req  in  2  per-requester access request.
- req_lock  in  2  keep the grant across consecutive requests; sampled only while that requester is granted.
- req_wen  in  2  per-requester write enable.
- req_addr  in  2x32  per-requester byte address.
- req_wdata  in  2x32  per-requester write data.
- req_size  in  2x3  per-requester access size code, passed through unchanged.
- gnt  out  2  one-hot grant; the access completes in the cycle gnt is high.
- rvalid  out  2  read data valid, routed to the issuing requester.
- rdata  out  32  shared read data bus; meaningful only where rvalid is high.
- m_wen  out  1  dmem write enable.
- m_addr  out  32  dmem address.
- m_wdata  out  32  dmem write data.
- m_size  out  3  dmem size code.
- m_rdata  in  32  dmem read data.

Behaviour:
- Reset values: gnt=0, rvalid=0, m_wen=0, m_addr=0, m_wdata=0, m_size=0.
- Reset state: state=IDLE, last_gnt=1 so requester 0 wins the first tie, burst_cnt=0, tag pipeline cleared.
- Reset mid-operation: in-flight reads are dropped; no rvalid is produced for them after reset is released.
- States:
  - IDLE: no lock held.
  - OWN0 / OWN1: a lock is held by requester 0 / 1.
- IDLE transitions, same-cycle combinational grant:
  - Only one requester asserts req: grant it.
  - Both assert req: grant the requester that is not last_gnt.
  - The granted requester also asserts req_lock: move to OWNx.
- OWNx transitions:
  - The owner is granted whenever it asserts req; the other requester is blocked.
  - Return to IDLE when the owner drops req_lock, or drops req for one cycle.
  - Return to IDLE when burst_cnt reaches MAX_BURST while the other requester asserts req. That cycle's grant goes to the other requester (forced release).
  - When the owner drops req while holding lock, the other requester may be granted that same cycle.
- burst_cnt:
  - Counts grants issued in OWNx and saturates at MAX_BURST.
  - Cleared on entry to or exit from OWNx.
  - The entry grant counts as 1.
- last_gnt updates on every grant.
- m_* outputs:
  - With a grant: combinationally muxed from the granted requester; m_wen = req_wen of the granted requester.
  - With no grant: m_wen=0 and m_addr/m_wdata/m_size hold their last driven values (registered hold).
- Read return:
  - A granted read (req_wen=0) pushes {valid, id} into a RD_LATENCY-deep shift register.
  - At the tail, rvalid[id]=1 and rdata=m_rdata.
  - Writes push valid=0.
- Throughput: one access per cycle, no bubbles when switching between requesters.
- Starvation bound: a waiting requester is granted within MAX_BURST+1 cycles.
- A requester must hold its request stable until it sees gnt; the arbiter does not check this.

Optional Feature:
- DMEM_ARB_STATS_EN defined:
  - Adds outputs stat_gnt0, stat_gnt1, stat_conflict, each 32 bits.
  - stat_gnt0 / stat_gnt1 count grants per requester.
  - stat_conflict counts cycles where exactly one of two simultaneous requests is denied, including cycles with a held lock.
  - Counters wrap at 2^32 and are cleared by reset.
- Not defined: the ports and counter logic are absent and all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum arb_state_t {IDLE, OWN0, OWN1};
  - the requester id type req_id_t (1 bit);
  - the size code constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, plus the unsigned variants shared with dmem.
- One natural sub-module: dmem_arb_rtag, the RD_LATENCY-deep {valid, id} shift register with asynchronous clear.

Test Plan:
- Reset with rst=0, then release: all outputs are 0. Then req=2'b11, both reads → gnt=01 at cycle 0 and gnt=10 at cycle 1. With RD_LATENCY=1: rvalid=01 at cycle 1 and rvalid=10 at cycle 2, with rdata = dmem words at 0x1000_0000 and 0x1000_0004.
- Requester 1 locks (req_lock[1]=1) while requester 0 requests continuously, MAX_BURST=8 → eight consecutive gnt=10, then gnt=01 on the ninth cycle, and state returns to IDLE.
- Interleaved traffic: requester 0 writes 0xDEADBEEF to 0x1000_0010 with size word, then requester 1 reads 0x1000_0010 → requester 1 receives rvalid[1] with rdata=0xDEADBEEF; rvalid[0] is never set.
- Assert rst=0 with two reads in flight (RD_LATENCY=2) → no rvalid after release, and the first grant after release goes to requester 0 on a tie.
- DMEM_ARB_STATS_EN defined: 10 cycles of a contended req=11 → stat_gnt0=5, stat_gnt1=5, stat_conflict=10.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the dmem arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  // Access size codes, identical to the encoding dmem decodes
  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HALF  = 3'd1;
  localparam logic [2:0] SZ_WORD  = 3'd2;
  localparam logic [2:0] SZ_BYTEU = 3'd4;
  localparam logic [2:0] SZ_HALFU = 3'd5;

  function automatic req_id_t other_id(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/dmem_arb_rtag.sv
// rtl/dmem_arb_rtag.sv - read-return tag pipeline, {valid, id} delayed by the dmem read latency
module dmem_arb_rtag
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_valid,
  input  req_id_t push_id,
  output logic    pop_valid,
  output req_id_t pop_id
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] ids;

  // Shift tags toward the tail; reset drops every in-flight read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      ids <= '0;
    end else begin
      vld[0] <= push_valid;
      ids[0] <= push_id;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        ids[i] <= ids[i-1];
      end
    end
  end

  assign pop_valid = vld[DEPTH-1];
  assign pop_id    = ids[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin dmem arbiter with burst lock; DMEM_ARB_STATS_EN adds grant/conflict counters
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  req_lock,
  input  logic [1:0]  req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [5:0]  req_size,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [31:0] rdata,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [2:0]  m_size,
  input  logic [31:0] m_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_gnt0,
  output logic [31:0] stat_gnt1,
  output logic [31:0] stat_conflict
`endif
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  arb_state_t  state, state_nxt;
  req_id_t     last_gnt;
  logic [7:0]  burst_cnt, burst_nxt;
  logic        win_vld;
  req_id_t     win_id;
  req_id_t     owner;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  size_q;
  logic        tag_valid;
  req_id_t     tag_id;

  // State register: lock state, round-robin pointer and burst counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      if (win_vld) last_gnt <= win_id;
    end
  end

  // Next state: pick this cycle's winner and track lock ownership
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    win_vld   = 1'b0;
    win_id    = 1'b0;
    owner     = 1'b0;
    case (state)
      IDLE: begin
        if (req[0] && req[1]) begin
          win_vld = 1'b1;
          win_id  = other_id(last_gnt);
        end else if (req[0] || req[1]) begin
          win_vld = 1'b1;
          win_id  = req[1];
        end
        if (win_vld && req_lock[win_id]) begin
          state_nxt = win_id ? OWN1 : OWN0;
          burst_nxt = 8'd1;
        end
      end
      OWN0, OWN1: begin
        owner = (state == OWN1);
        if (burst_cnt >= MAX_B && req[other_id(owner)]) begin
          // Burst exhausted with the other side waiting: hand it this cycle
          win_vld   = 1'b1;
          win_id    = other_id(owner);
          state_nxt = IDLE;
          burst_nxt = '0;
        end else if (req[owner]) begin
          win_vld = 1'b1;
          win_id  = owner;
          if (req_lock[owner]) begin
            burst_nxt = (burst_cnt >= MAX_B) ? MAX_B : burst_cnt + 8'd1;
          end else begin
            state_nxt = IDLE;
            burst_nxt = '0;
          end
        end else begin
          // Owner paused: release the lock and let the other side in now
          win_vld   = req[other_id(owner)];
          win_id    = other_id(owner);
          state_nxt = IDLE;
          burst_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        burst_nxt = '0;
      end
    endcase
  end

  // Outputs: one-hot grant and dmem mux; idle cycles replay the held request fields
  always_comb begin
    gnt     = '0;
    m_wen   = 1'b0;
    m_addr  = addr_q;
    m_wdata = wdata_q;
    m_size  = size_q;
    if (rst && win_vld) begin
      gnt[win_id] = 1'b1;
      m_wen       = req_wen[win_id];
      m_addr      = win_id ? req_addr[63:32]  : req_addr[31:0];
      m_wdata     = win_id ? req_wdata[63:32] : req_wdata[31:0];
      m_size      = win_id ? req_size[5:3]    : req_size[2:0];
    end
  end

  // Hold the last driven dmem request fields across idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
    end else if (|gnt) begin
      addr_q  <= m_addr;
      wdata_q <= m_wdata;
      size_q  <= m_size;
    end
  end

  dmem_arb_rtag #(.DEPTH(RD_LATENCY)) u_rtag (
    .clk        (clk),
    .rst        (rst),
    .push_valid (|gnt && !m_wen),
    .push_id    (win_id),
    .pop_valid  (tag_valid),
    .pop_id     (tag_id)
  );

  assign rvalid = {tag_valid && tag_id, tag_valid && !tag_id};
  assign rdata  = m_rdata;

`ifdef DMEM_ARB_STATS_EN
  // Free-running grant and contention counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt[0]) stat_gnt0 <= stat_gnt0 + 32'd1;
      if (gnt[1]) stat_gnt1 <= stat_gnt1 + 32'd1;
      if (&req && |gnt) stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector bench for dmem_arbiter (latency 1 and 2 instances)
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, req_lock, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [5:0]  req_size;

  logic [1:0]  a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, a_m_addr, a_m_wdata, a_m_rdata;
  logic [31:0] b_rdata, b_m_addr, b_m_wdata, b_m_rdata;
  logic        a_m_wen, b_m_wen;
  logic [2:0]  a_m_size, b_m_size;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] a_sg0, a_sg1, a_sc, b_sg0, b_sg1, b_sc;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  dmem_arbiter #(.RD_LATENCY(1), .MAX_BURST(8)) u_a (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata), .m_wen(a_m_wen),
    .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_size(a_m_size), .m_rdata(a_m_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_gnt0(a_sg0), .stat_gnt1(a_sg1), .stat_conflict(a_sc)
`endif
  );

  dmem_arbiter #(.RD_LATENCY(2), .MAX_BURST(8)) u_b (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .m_wen(b_m_wen),
    .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_size(b_m_size), .m_rdata(b_m_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_gnt0(b_sg0), .stat_gnt1(b_sg1), .stat_conflict(b_sc)
`endif
  );

  // One-cycle dmem model behind the latency-1 instance
  always @(posedge clk) begin
    if (a_m_wen) mem[a_m_addr[7:2]] <= a_m_wdata;
    a_m_rdata <= mem[a_m_addr[7:2]];
  end

  assign b_m_rdata = 32'h5A5A_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                       input logic [31:0] ad0, input logic [31:0] ad1, input logic [31:0] wd0);
    req       = r;
    req_lock  = l;
    req_wen   = w;
    req_addr  = {ad1, ad0};
    req_wdata = {32'h0, wd0};
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_gnt"},    {30'b0, a_gnt, b_gnt} , 32'h0);
    chk({tag, "_rvalid"}, {30'b0, a_rvalid, b_rvalid}, 32'h0);
    chk({tag, "_m_wen"},  {30'b0, a_m_wen, b_m_wen}, 32'h0);
    chk({tag, "_m_addr"}, a_m_addr | b_m_addr, 32'h0);
    chk({tag, "_m_wdata"}, a_m_wdata | b_m_wdata, 32'h0);
    chk({tag, "_m_size"}, {26'b0, a_m_size, b_m_size}, 32'h0);
  endtask

  typedef struct {
    logic [1:0]  req, lock, wen;
    logic [31:0] addr0, addr1, wdata0;
    logic [1:0]  e_gnt, e_rvalid;
    logic        e_chk_rdata;
    logic [31:0] e_rdata;
    logic        e_wen;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_size;
  } vec_t;

  vec_t vecs [9];
  int   exp_g;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);

    // Both read back-to-back, then a word write by 0 read back by 1
    vecs[0] = '{2'b11, 2'b00, 2'b00, 32'h1000_0000, 32'h1000_0004, 32'h0,
                2'b01, 2'b00, 1'b0, 32'h0,          1'b0, 32'h1000_0000, 32'h0, 3'd2};
    vecs[1] = '{2'b11, 2'b00, 2'b00, 32'h1000_0000, 32'h1000_0004, 32'h0,
                2'b10, 2'b01, 1'b1, 32'hC0DE_0000, 1'b0, 32'h1000_0004, 32'h0, 3'd1};
    vecs[2] = '{2'b11, 2'b00, 2'b00, 32'h1000_0000, 32'h1000_0004, 32'h0,
                2'b01, 2'b10, 1'b1, 32'hC0DE_0001, 1'b0, 32'h1000_0000, 32'h0, 3'd2};
    vecs[3] = '{2'b00, 2'b00, 2'b00, 32'h1000_0000, 32'h1000_0004, 32'h0,
                2'b00, 2'b01, 1'b1, 32'hC0DE_0000, 1'b0, 32'h1000_0000, 32'h0, 3'd2};
    vecs[4] = '{2'b00, 2'b00, 2'b00, 32'h1000_0000, 32'h1000_0004, 32'h0,
                2'b00, 2'b00, 1'b0, 32'h0,          1'b0, 32'h1000_0000, 32'h0, 3'd2};
    vecs[5] = '{2'b01, 2'b00, 2'b01, 32'h1000_0010, 32'h1000_0010, 32'hDEAD_BEEF,
                2'b01, 2'b00, 1'b0, 32'h0,          1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 3'd2};
    vecs[6] = '{2'b10, 2'b00, 2'b00, 32'h1000_0010, 32'h1000_0010, 32'h0,
                2'b10, 2'b00, 1'b0, 32'h0,          1'b0, 32'h1000_0010, 32'h0, 3'd1};
    vecs[7] = '{2'b00, 2'b00, 2'b00, 32'h1000_0010, 32'h1000_0010, 32'h0,
                2'b00, 2'b10, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h1000_0010, 32'h0, 3'd1};
    vecs[8] = '{2'b00, 2'b00, 2'b00, 32'h1000_0010, 32'h1000_0010, 32'h0,
                2'b00, 2'b00, 1'b0, 32'h0,          1'b0, 32'h1000_0010, 32'h0, 3'd1};

    rst      = 1'b0;
    req_size = {SZ_HALF, SZ_WORD};
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    chk_zero_outputs("in_reset");
    rst = 1'b1;
    #4;
    chk_zero_outputs("after_reset");

    // Table-driven traffic
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      drive(vecs[i].req, vecs[i].lock, vecs[i].wen, vecs[i].addr0, vecs[i].addr1, vecs[i].wdata0);
      #4;
      chk($sformatf("v%0d_gnt", i),    {30'b0, a_gnt},    {30'b0, vecs[i].e_gnt});
      chk($sformatf("v%0d_rvalid", i), {30'b0, a_rvalid}, {30'b0, vecs[i].e_rvalid});
      if (vecs[i].e_chk_rdata) chk($sformatf("v%0d_rdata", i), a_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_m_wen", i),   {31'b0, a_m_wen},  {31'b0, vecs[i].e_wen});
      chk($sformatf("v%0d_m_addr", i),  a_m_addr,  vecs[i].e_addr);
      chk($sformatf("v%0d_m_wdata", i), a_m_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_m_size", i),  {29'b0, a_m_size}, {29'b0, vecs[i].e_size});
    end

    // Requester 1 locks against a continuously requesting requester 0
    next_cycle();
    drive(2'b01, 2'b00, 2'b11, 32'h1000_0020, 32'h1000_0024, 32'h0);
    #4;
    chk("lock_pre_gnt", {30'b0, a_gnt}, 32'h1);
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      drive(2'b11, 2'b10, 2'b11, 32'h1000_0020, 32'h1000_0024, 32'h0);
      #4;
      exp_g = (i < 8) ? 2 : 1;
      chk($sformatf("burst%0d_gnt", i), {30'b0, a_gnt}, 32'(exp_g));
    end
    next_cycle();
    drive(2'b00, 2'b00, 2'b11, 32'h1000_0020, 32'h1000_0024, 32'h0);
    #4;
    chk("burst_release_state", 32'(u_a.state), 32'(IDLE));

    // Requester 0 locks, blocks 1, then drops the lock
    next_cycle(); drive(2'b01, 2'b01, 2'b11, 32'h1000_0020, 32'h1000_0024, 32'h0); #4;
    chk("own0_enter_gnt", {30'b0, a_gnt}, 32'h1);
    next_cycle(); drive(2'b11, 2'b01, 2'b11, 32'h1000_0020, 32'h1000_0024, 32'h0); #4;
    chk("own0_block_gnt", {30'b0, a_gnt}, 32'h1);
    next_cycle(); drive(2'b11, 2'b00, 2'b11, 32'h1000_0020, 32'h1000_0024, 32'h0); #4;
    chk("own0_unlock_gnt", {30'b0, a_gnt}, 32'h1);
    next_cycle(); drive(2'b11, 2'b00, 2'b11, 32'h1000_0020, 32'h1000_0024, 32'h0); #4;
    chk("own0_after_gnt", {30'b0, a_gnt}, 32'h2);

    // Requester 1 locks, then pauses its request: 0 gets in the same cycle
    next_cycle(); drive(2'b10, 2'b10, 2'b11, 32'h1000_0020, 32'h1000_0024, 32'h0); #4;
    chk("own1_enter_gnt", {30'b0, a_gnt}, 32'h2);
    next_cycle(); drive(2'b01, 2'b10, 2'b11, 32'h1000_0020, 32'h1000_0024, 32'h0); #4;
    chk("own1_pause_gnt", {30'b0, a_gnt}, 32'h1);
    next_cycle(); drive(2'b11, 2'b00, 2'b11, 32'h1000_0020, 32'h1000_0024, 32'h0); #4;
    chk("own1_idle_gnt", {30'b0, a_gnt}, 32'h2);

    // Two reads in flight, then an asynchronous reset pulse
    next_cycle(); drive(2'b11, 2'b00, 2'b00, 32'h1000_0000, 32'h1000_0004, 32'h0); #4;
    chk("rst_r0_gnt", {30'b0, a_gnt, b_gnt}, 32'h5);
    next_cycle(); drive(2'b01, 2'b00, 2'b00, 32'h1000_0000, 32'h1000_0004, 32'h0); #4;
    chk("rst_r1_gnt", {30'b0, a_gnt, b_gnt}, 32'h5);
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
    chk("pre_rst_rvalid", {30'b0, a_rvalid, b_rvalid}, 32'h5);
    rst = 1'b0;
    #2;
    chk("rst_pulse_rvalid", {30'b0, a_rvalid, b_rvalid}, 32'h0);
    rst = 1'b1;
    #1;
    chk_zero_outputs("rst_release");
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #4;
      chk($sformatf("post_rst%0d_rvalid", i), {30'b0, a_rvalid, b_rvalid}, 32'h0);
    end

    // Contended stream after reset: strict alternation starting with requester 0
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(2'b11, 2'b00, 2'b00, 32'h1000_0000, 32'h1000_0004, 32'h0);
      #4;
      exp_g = (i % 2 == 0) ? 5 : 10;
      chk($sformatf("rr%0d_gnt", i), {30'b0, a_gnt, b_gnt}, 32'(exp_g));
    end
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
    #4;
`ifdef DMEM_ARB_STATS_EN
    chk("stat_gnt0_a", a_sg0, 32'd5);
    chk("stat_gnt1_a", a_sg1, 32'd5);
    chk("stat_conflict_a", a_sc, 32'd10);
    chk("stat_gnt0_b", b_sg0, 32'd5);
    chk("stat_gnt1_b", b_sg1, 32'd5);
    chk("stat_conflict_b", b_sc, 32'd10);
`endif
    chk("b_rdata_passthru", b_rdata, 32'h5A5A_0000);
    chk("b_idle_hold", {b_m_addr[31:4], 1'b0, b_m_size}, {28'h1000_000, 1'b0, 3'd1});
    chk("b_idle_wdata", b_m_wdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
